// File: rtl/me_load_controller.sv
`default_nettype none
// ============================================================================
// Module   : me_load_controller
// Function : Streams the search window and reference block into the ME core,
//            runs the core until done or timeout, and returns the SAD result.
// Revision : 1.0 - initial release
// ============================================================================
module me_load_controller #(
   parameter int DATA_WIDTH      = 8,
   parameter int SW_MEMORY_DEPTH = 961,
   parameter int RB_MEMORY_DEPTH = 256,
   parameter int MAX_DATA_WIDTH  = 16,
   parameter int TIMEOUT_CYCLES  = 65535
) (
   input  logic                               in_clk,
   input  logic                               in_rst,
   input  logic                               in_start,
   input  logic                               in_pix_valid,
   input  logic [DATA_WIDTH-1:0]              in_pix_data,
   output logic                               out_pix_ready,
   output logic                               out_sw_write_en,
   output logic [$clog2(SW_MEMORY_DEPTH)-1:0] out_sw_write_addr,
   output logic [DATA_WIDTH-1:0]              out_sw_write_data,
   output logic                               out_rb_write_en,
   output logic [$clog2(RB_MEMORY_DEPTH)-1:0] out_rb_write_addr,
   output logic [DATA_WIDTH-1:0]              out_rb_write_data,
   output logic                               out_me_enable,
   input  logic                               in_me_done,
   input  logic [MAX_DATA_WIDTH-1:0]          in_me_min_sad,
   output logic                               out_result_valid,
   input  logic                               in_result_ready,
   output logic [MAX_DATA_WIDTH-1:0]          out_result_sad,
   output logic                               out_result_timeout,
   output logic [31:0]                        out_cycle_count,
   output logic                               out_busy
);

   localparam int SW_AW  = $clog2(SW_MEMORY_DEPTH);
   localparam int RB_AW  = $clog2(RB_MEMORY_DEPTH);
   localparam int BEAT_W = (SW_AW > RB_AW) ? SW_AW : RB_AW;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD_SW = 3'd1,
      S_LOAD_RB = 3'd2,
      S_GAP     = 3'd3,
      S_RUN     = 3'd4,
      S_RESULT  = 3'd5
   } state_t;

   state_t                    state_q, state_d;
   logic [BEAT_W-1:0]         beat_q, beat_d;
   logic                      gap_q, gap_d;
   logic [31:0]               count_q, count_d;
   logic                      sw_we_q, sw_we_d;
   logic [SW_AW-1:0]          sw_addr_q, sw_addr_d;
   logic [DATA_WIDTH-1:0]     sw_data_q, sw_data_d;
   logic                      rb_we_q, rb_we_d;
   logic [RB_AW-1:0]          rb_addr_q, rb_addr_d;
   logic [DATA_WIDTH-1:0]     rb_data_q, rb_data_d;
   logic                      ready_q, ready_d;
   logic                      enable_q, enable_d;
   logic                      valid_q, valid_d;
   logic [MAX_DATA_WIDTH-1:0] sad_q, sad_d;
   logic                      timeout_q, timeout_d;
   logic                      busy_q, busy_d;
   logic                      w_accept;

   // ready_q is high exactly in the LOAD states, so it doubles as the accept gate
   assign w_accept = in_pix_valid && ready_q;

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         state_q   <= S_IDLE;
         beat_q    <= '0;
         gap_q     <= 1'b0;
         count_q   <= '0;
         sw_we_q   <= 1'b0;
         sw_addr_q <= '0;
         sw_data_q <= '0;
         rb_we_q   <= 1'b0;
         rb_addr_q <= '0;
         rb_data_q <= '0;
         ready_q   <= 1'b0;
         enable_q  <= 1'b0;
         valid_q   <= 1'b0;
         sad_q     <= '0;
         timeout_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         gap_q     <= gap_d;
         count_q   <= count_d;
         sw_we_q   <= sw_we_d;
         sw_addr_q <= sw_addr_d;
         sw_data_q <= sw_data_d;
         rb_we_q   <= rb_we_d;
         rb_addr_q <= rb_addr_d;
         rb_data_q <= rb_data_d;
         ready_q   <= ready_d;
         enable_q  <= enable_d;
         valid_q   <= valid_d;
         sad_q     <= sad_d;
         timeout_q <= timeout_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      gap_d     = gap_q;
      count_d   = count_q;
      sw_we_d   = 1'b0;
      sw_addr_d = sw_addr_q;
      sw_data_d = sw_data_q;
      rb_we_d   = 1'b0;
      rb_addr_d = rb_addr_q;
      rb_data_d = rb_data_q;
      sad_d     = sad_q;
      timeout_d = timeout_q;

      case (state_q)
         S_IDLE: begin
            if (in_start) begin
               state_d = S_LOAD_SW;
               beat_d  = '0;
               count_d = '0;
            end
         end
         S_LOAD_SW: begin
            if (w_accept) begin
               sw_we_d   = 1'b1;
               sw_addr_d = SW_AW'(beat_q);
               sw_data_d = in_pix_data;
               if (beat_q == BEAT_W'(SW_MEMORY_DEPTH - 1)) begin
                  state_d = S_LOAD_RB;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         S_LOAD_RB: begin
            if (w_accept) begin
               rb_we_d   = 1'b1;
               rb_addr_d = RB_AW'(beat_q);
               rb_data_d = in_pix_data;
               if (beat_q == BEAT_W'(RB_MEMORY_DEPTH - 1)) begin
                  state_d = S_GAP;
                  beat_d  = '0;
                  gap_d   = 1'b0;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         S_GAP: begin
            if (gap_q) begin
               state_d = S_RUN;
            end else begin
               gap_d = 1'b1;
            end
         end
         S_RUN: begin
            // The current enable cycle is counted, including the one that sees done
            count_d = count_q + 32'd1;
            if (in_me_done) begin
               sad_d     = in_me_min_sad;
               timeout_d = 1'b0;
               state_d   = S_RESULT;
            end else if (count_d == 32'(TIMEOUT_CYCLES)) begin
               sad_d     = {MAX_DATA_WIDTH{1'b1}};
               timeout_d = 1'b1;
               state_d   = S_RESULT;
            end
         end
         S_RESULT: begin
            if (in_result_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Status outputs follow the next state so they are registered yet aligned
      ready_d  = (state_d == S_LOAD_SW) || (state_d == S_LOAD_RB);
      enable_d = (state_d == S_RUN);
      valid_d  = (state_d == S_RESULT);
      busy_d   = (state_d != S_IDLE);
   end

   assign out_pix_ready      = ready_q;
   assign out_sw_write_en    = sw_we_q;
   assign out_sw_write_addr  = sw_addr_q;
   assign out_sw_write_data  = sw_data_q;
   assign out_rb_write_en    = rb_we_q;
   assign out_rb_write_addr  = rb_addr_q;
   assign out_rb_write_data  = rb_data_q;
   assign out_me_enable      = enable_q;
   assign out_result_valid   = valid_q;
   assign out_result_sad     = sad_q;
   assign out_result_timeout = timeout_q;
   assign out_cycle_count    = count_q;
   assign out_busy           = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_me_load_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_me_load_controller
// Function : Directed self-checking bench for me_load_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_me_load_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_a = 1'b0, start_b = 1'b0;
   logic        pix_valid = 1'b0;
   logic [7:0]  pix_data = 8'h00;
   logic        done = 1'b0;
   logic [15:0] min_sad = 16'h0000;
   logic        res_ready = 1'b0;

   logic        rdy_a, swwe_a, rbwe_a, en_a, val_a, to_a, busy_a;
   logic [9:0]  swad_a;
   logic [7:0]  swd_a, rbad_a, rbd_a;
   logic [15:0] sad_a;
   logic [31:0] cnt_a;

   logic        rdy_b, swwe_b, rbwe_b, en_b, val_b, to_b, busy_b;
   logic [9:0]  swad_b;
   logic [7:0]  swd_b, rbad_b, rbd_b;
   logic [15:0] sad_b;
   logic [31:0] cnt_b;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int sw_cnt   = 0;
   int rb_cnt   = 0;

   me_load_controller u_dut_a (
      .in_clk(clk), .in_rst(rst), .in_start(start_a),
      .in_pix_valid(pix_valid), .in_pix_data(pix_data), .out_pix_ready(rdy_a),
      .out_sw_write_en(swwe_a), .out_sw_write_addr(swad_a), .out_sw_write_data(swd_a),
      .out_rb_write_en(rbwe_a), .out_rb_write_addr(rbad_a), .out_rb_write_data(rbd_a),
      .out_me_enable(en_a), .in_me_done(done), .in_me_min_sad(min_sad),
      .out_result_valid(val_a), .in_result_ready(res_ready),
      .out_result_sad(sad_a), .out_result_timeout(to_a),
      .out_cycle_count(cnt_a), .out_busy(busy_a)
   );

   // Second instance with a short timeout; its core never signals done
   me_load_controller #(.TIMEOUT_CYCLES(50)) u_dut_b (
      .in_clk(clk), .in_rst(rst), .in_start(start_b),
      .in_pix_valid(pix_valid), .in_pix_data(pix_data), .out_pix_ready(rdy_b),
      .out_sw_write_en(swwe_b), .out_sw_write_addr(swad_b), .out_sw_write_data(swd_b),
      .out_rb_write_en(rbwe_b), .out_rb_write_addr(rbad_b), .out_rb_write_data(rbd_b),
      .out_me_enable(en_b), .in_me_done(1'b0), .in_me_min_sad(min_sad),
      .out_result_valid(val_b), .in_result_ready(res_ready),
      .out_result_sad(sad_b), .out_result_timeout(to_b),
      .out_cycle_count(cnt_b), .out_busy(busy_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Write-port scoreboard for instance A: strictly in-order addresses and stream data
   always @(negedge clk) begin
      if (!rst) begin
         if (swwe_a) begin
            check("sw_addr", 64'(swad_a), 64'(sw_cnt));
            check("sw_data", 64'(swd_a), 64'(sw_cnt % 256));
         end
         if (rbwe_a) begin
            check("rb_addr", 64'(rbad_a), 64'(rb_cnt));
            check("rb_data", 64'(rbd_a), 64'((961 + rb_cnt) % 256));
         end
         if ((swwe_a || rbwe_a) && !busy_a)
            check("write_in_idle", 64'(1), 64'(0));
      end
      if (rst || !busy_a) begin
         sw_cnt <= 0;
         rb_cnt <= 0;
      end else begin
         if (swwe_a) sw_cnt <= sw_cnt + 1;
         if (rbwe_a) rb_cnt <= rb_cnt + 1;
      end
   end

   task automatic start_job(input bit sel_b);
      @(posedge clk); #1;
      if (sel_b) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   // mode 0: continuous valid; mode 1: valid every other cycle with random stalls
   task automatic stream(input bit sel_b, input int mode, input int n_beats, output int last_cyc);
      int  i = 0;
      int  k = 0;
      logic rdy;
      last_cyc = 0;
      while (i < n_beats && k < 6000) begin
         @(posedge clk); #1;
         pix_valid = (mode == 0) ? 1'b1 : ((k % 2 == 0) && ($urandom_range(0, 3) != 0));
         pix_data  = 8'(i % 256);
         @(negedge clk);
         rdy = sel_b ? rdy_b : rdy_a;
         if (pix_valid && rdy) begin
            i++;
            last_cyc = cyc;
         end
         k++;
      end
      check("stream_beats", 64'(i), 64'(n_beats));
      @(posedge clk); #1;
      pix_valid = 1'b0;
   endtask

   // Leaves the bench at the negedge of the first enable cycle
   task automatic wait_enable(input int last_cyc);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
         if (!en_a) check("gap_ready", 64'(rdy_a), 64'(0));
      end while (!en_a && n < 20);
      check("en_delay", 64'(cyc - last_cyc), 64'(3));
   endtask

   task automatic finish_job(input int n_en, input logic [15:0] sad_v);
      repeat (n_en - 1) @(posedge clk);
      #1;
      done    = 1'b1;
      min_sad = sad_v;
      @(negedge clk);
      check("en_at_done", 64'(en_a), 64'(1));
      check("valid_at_done", 64'(val_a), 64'(0));
      @(posedge clk); #1;
      done    = 1'b0;
      min_sad = 16'h0000;
      @(negedge clk);
      check("en_after_done", 64'(en_a), 64'(0));
      check("res_valid", 64'(val_a), 64'(1));
      check("res_sad", 64'(sad_a), 64'(sad_v));
      check("res_count", 64'(cnt_a), 64'(n_en));
      check("res_timeout", 64'(to_a), 64'(0));
      check("sw_total", 64'(sw_cnt), 64'(961));
      check("rb_total", 64'(rb_cnt), 64'(256));
      @(posedge clk); #1;
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      @(negedge clk);
      check("valid_after_hs", 64'(val_a), 64'(0));
      check("busy_after_hs", 64'(busy_a), 64'(0));
   endtask

   initial begin
      int lc;
      int n;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_ctrl", 64'({rdy_a, swwe_a, rbwe_a, en_a, val_a, to_a, busy_a}), 64'(0));
      check("rst_data", 64'({swad_a, swd_a, rbad_a, rbd_a}), 64'(0));
      check("rst_res", 64'({sad_a, cnt_a}), 64'(0));
      rst = 1'b0;
      @(negedge clk);
      check("idle_ready", 64'(rdy_a), 64'(0));

      // Job 1: continuous stream, done after 100 enable cycles, held result
      start_job(1'b0);
      @(negedge clk);
      check("ready_after_start", 64'(rdy_a), 64'(1));
      stream(1'b0, 0, 1217, lc);
      @(negedge clk);
      check("final_rb_write", 64'(rbwe_a), 64'(1));
      check("ready_drop", 64'(rdy_a), 64'(0));
      wait_enable(lc);
      repeat (99) @(posedge clk);
      #1;
      done    = 1'b1;
      min_sad = 16'h0123;
      @(negedge clk);
      check("j1_en_at_done", 64'(en_a), 64'(1));
      @(posedge clk); #1;
      done    = 1'b0;
      min_sad = 16'h0000;
      @(negedge clk);
      check("j1_en_low", 64'(en_a), 64'(0));
      check("j1_valid", 64'(val_a), 64'(1));
      check("j1_sad", 64'(sad_a), 64'h0123);
      check("j1_count", 64'(cnt_a), 64'(100));
      check("j1_timeout", 64'(to_a), 64'(0));
      check("j1_sw_total", 64'(sw_cnt), 64'(961));
      check("j1_rb_total", 64'(rb_cnt), 64'(256));
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         start_a = (k == 1);
         @(negedge clk);
         check("hold_valid", 64'(val_a), 64'(1));
         check("hold_fields", 64'({to_a, sad_a, cnt_a}), {15'd0, 1'b0, 16'h0123, 32'd100});
         check("hold_no_load", 64'(rdy_a), 64'(0));
      end
      @(posedge clk); #1;
      start_a   = 1'b0;
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      @(negedge clk);
      check("j1_idle_valid", 64'(val_a), 64'(0));
      check("j1_idle_busy", 64'(busy_a), 64'(0));
      check("j1_count_kept", 64'(cnt_a), 64'(100));
      @(negedge clk);
      check("j1_start_ignored", 64'(rdy_a), 64'(0));

      // Job 2: sparse stream with random stalls
      start_job(1'b0);
      stream(1'b0, 1, 1217, lc);
      wait_enable(lc);
      finish_job(7, 16'h0abc);

      // Job 3: timeout on the short-timeout instance
      start_job(1'b1);
      stream(1'b1, 0, 1217, lc);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!val_b && n < 200);
      check("to_valid", 64'(val_b), 64'(1));
      check("to_flag", 64'(to_b), 64'(1));
      check("to_sad", 64'(sad_b), 64'hffff);
      check("to_count", 64'(cnt_b), 64'(50));
      check("to_en_low", 64'(en_b), 64'(0));
      @(posedge clk); #1;
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      @(negedge clk);
      check("to_idle", 64'({val_b, busy_b}), 64'(0));

      // Job 4: reset in the middle of the reference-block load, then a clean job
      start_job(1'b0);
      stream(1'b0, 0, 1000, lc);
      rst = 1'b1;
      #1;
      check("mid_rst_ctrl", 64'({rdy_a, swwe_a, rbwe_a, en_a, val_a, to_a, busy_a}), 64'(0));
      check("mid_rst_data", 64'({swad_a, swd_a, rbad_a, rbd_a}), 64'(0));
      check("mid_rst_res", 64'({sad_a, cnt_a}), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      start_job(1'b0);
      stream(1'b0, 0, 1217, lc);
      wait_enable(lc);
      finish_job(5, 16'h0042);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
